// File: rtl/cgol_pkg.sv
// cgol_pkg: shared state encoding and the Game-of-Life cell rule.
package cgol_pkg;
  typedef enum logic [1:0] {IDLE, RUN, COMPUTE, COMMIT} life_state_t;
  function automatic logic life_rule(input logic center, input logic [3:0] n);
    return (n == 4'd3) || (center && n == 4'd2);
  endfunction
endpackage

// File: rtl/life_row_next.sv
// life_row_next: combinational next-generation row from the rows above, at and below it.
module life_row_next
  import cgol_pkg::*;
#(
  parameter int COLS = 8,
  parameter int WRAP = 1
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] nxt_row
);
  for (genvar c = 0; c < COLS; c++) begin : g_cell
    localparam int L = (c == 0) ? COLS - 1 : c - 1;
    localparam int R = (c == COLS - 1) ? 0 : c + 1;
    localparam bit LM = (WRAP != 0) || (c != 0);
    localparam bit RM = (WRAP != 0) || (c != COLS - 1);
    logic [3:0] n;
    assign n = 4'(above[L] & LM) + 4'(above[c]) + 4'(above[R] & RM)
             + 4'(cur[L] & LM) + 4'(cur[R] & RM)
             + 4'(below[L] & LM) + 4'(below[c]) + 4'(below[R] & RM);
    assign nxt_row[c] = life_rule(cur[c], n);
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: double-buffered Game-of-Life core with run/step control, host load and LED scan.
module life_engine
  import cgol_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int WRAP       = 1,
  parameter int GEN_FRAMES = 64,
  parameter int GEN_W      = 16,
  localparam int AW        = $clog2(ROWS),
  localparam int FW        = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [COLS-1:0]  load_data,
  output logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic             busy,
  output logic             halted,
  output logic [GEN_W-1:0] gen_count
);
  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);
  typedef struct packed {
    life_state_t                 st;
    logic [AW-1:0]               scan;
    logic [AW-1:0]               rc;
    logic [FW-1:0]               frame;
    logic [ROWS-1:0]             row;
    logic [COLS-1:0]             col;
    logic [ROWS-1:0][COLS-1:0]   cur;
    logic [ROWS-1:0][COLS-1:0]   nxt;
    logic                        halted;
    logic [GEN_W-1:0]            gen;
  } regs_t;
  regs_t q, m, d;
  logic [AW-1:0] ra, rb;
  logic [COLS-1:0] above, below, nrow;
  logic hn;
  assign ra = (q.rc == '0) ? LAST : q.rc - AW'(1);
  assign rb = (q.rc == LAST) ? '0 : q.rc + AW'(1);
  assign above = (WRAP == 0 && q.rc == '0) ? '0 : q.cur[ra];
  assign below = (WRAP == 0 && q.rc == LAST) ? '0 : q.cur[rb];
  assign hn = (q.nxt == '0) || (q.nxt == q.cur);
  life_row_next #(.COLS(COLS), .WRAP(WRAP)) u_row (
    .above(above), .cur(q.cur[q.rc]), .below(below), .nxt_row(nrow)
  );
  always_comb begin
    d = q;
    d.scan = (q.scan == LAST) ? '0 : q.scan + AW'(1);
    d.row = ROWS'(1) << q.scan;
    d.col = ~q.cur[q.scan];
    case (q.st)
      IDLE:
        if (load_en) begin
          if ({1'b0, load_addr} < (AW+1)'(ROWS)) d.cur[load_addr] = load_data;
          d.halted = 1'b0;
          d.gen = '0;
        end else if (step) begin
          d.st = COMPUTE;
          d.rc = '0;
        end else if (run && !q.halted) begin
          d.st = RUN;
          d.frame = '0;
        end
      RUN:
        if (!run) d.st = IDLE;
        else if (q.scan == LAST) begin
          d.frame = q.frame + FW'(1);
          if (q.frame == FW'(GEN_FRAMES - 1)) begin
            d.st = COMPUTE;
            d.rc = '0;
            d.frame = '0;
          end
        end
      COMPUTE: begin
        d.row = '0;
        d.col = '1;
        d.nxt[q.rc] = nrow;
        d.rc = q.rc + AW'(1);
        d.st = (q.rc == LAST) ? COMMIT : COMPUTE;
      end
      default: begin
        d.row = '0;
        d.col = '1;
        d.cur = q.nxt;
        d.gen = q.gen + GEN_W'(1);
        d.halted = hn;
        d.st = (run && !hn) ? RUN : IDLE;
        d.scan = '0;
        d.frame = '0;
      end
    endcase
    if (!reset) begin
      d = '0;
      d.col = '1;
    end
  end
  // master captures on ph2, slave presents on ph1
  always_ff @(posedge ph2) m <= d;
  always_ff @(posedge ph1) q <= m;
  assign row = q.row;
  assign col = q.col;
  assign busy = (q.st == COMPUTE) || (q.st == COMMIT);
  assign halted = q.halted;
  assign gen_count = q.gen;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of scan, step, run/halt, wrap modes, glider period and reset abort.
module tb_life_engine;
  import cgol_pkg::*;
  logic ph1, ph2, reset, run, step, load_en;
  logic [2:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] row1, col1, row0, col0;
  logic busy1, halted1, busy0, halted0;
  logic [15:0] gen1, gen0;
  int tests = 0, fails = 0;

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_FRAMES(1), .GEN_W(16)) u1 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .run(run), .step(step), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .row(row1), .col(col1),
    .busy(busy1), .halted(halted1), .gen_count(gen1)
  );
  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_FRAMES(1), .GEN_W(16)) u0 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .run(run), .step(step), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .row(row0), .col(col0),
    .busy(busy0), .halted(halted0), .gen_count(gen0)
  );

  initial begin
    ph1 = 0;
    ph2 = 0;
    forever begin
      #1 ph1 = 1;
      #3 ph1 = 0;
      #1 ph2 = 1;
      #3 ph2 = 0;
      #2;
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (3) tick();
    reset = 1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] v);
    load_en = 1;
    load_addr = a;
    load_data = v;
    tick();
    load_en = 0;
  endtask

  task automatic do_step();
    step = 1;
    tick();
    step = 0;
    repeat (9) tick();
  endtask

  initial begin
    reset = 0; run = 0; step = 0; load_en = 0; load_addr = 0; load_data = 0;
    do_reset();
    chk("rst_row", 64'(row1), 64'h0);
    chk("rst_col", 64'(col1), 64'hFF);
    chk("rst_busy", 64'(busy1), 64'h0);
    chk("rst_halted", 64'(halted1), 64'h0);
    chk("rst_gen", 64'(gen1), 64'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("scan_row", 64'(row1), 64'(8'h01 << ((k - 1) % 8)));
      chk("scan_col", 64'(col1), 64'hFF);
    end
    chk("idle_gen", 64'(gen1), 64'h0);
    chk("idle_halted", 64'(halted1), 64'h0);

    load(3, 8'b0001_1100);
    step = 1;
    tick();
    step = 0;
    for (int i = 0; i < 9; i++) begin
      chk("busy", 64'(busy1), 64'h1);
      tick();
    end
    chk("busy_done", 64'(busy1), 64'h0);
    chk("blinker_v", 64'(u1.q.cur), 64'h00000008_08080000);
    chk("blinker_gen", 64'(gen1), 64'h1);
    chk("blinker_halted", 64'(halted1), 64'h0);
    do_step();
    chk("blinker_h", 64'(u1.q.cur), 64'h00000000_1C000000);
    chk("blinker_gen2", 64'(gen1), 64'h2);
    chk("blinker_halted2", 64'(halted1), 64'h0);
    load(0, 8'h00);
    chk("load_clr_gen", 64'(gen1), 64'h0);

    do_reset();
    load(1, 8'b0000_0110);
    load(2, 8'b0000_0110);
    run = 1;
    for (int i = 0; i < 100 && halted1 !== 1'b1; i++) tick();
    chk("block_halted", 64'(halted1), 64'h1);
    chk("block_gen", 64'(gen1), 64'h1);
    repeat (20) tick();
    chk("block_idle", 64'(u1.q.st), 64'(IDLE));
    chk("block_gen_hold", 64'(gen1), 64'h1);
    chk("block_grid", 64'(u1.q.cur), 64'h00000000_00060600);
    run = 0;

    do_reset();
    load(0, 8'b1000_0011);
    do_step();
    chk("wrap1_grid", 64'(u1.q.cur), 64'h01000000_00000101);
    chk("wrap1_halted", 64'(halted1), 64'h0);
    chk("wrap0_grid", 64'(u0.q.cur), 64'h0);
    chk("wrap0_halted", 64'(halted0), 64'h1);
    chk("wrap0_gen", 64'(gen0), 64'h1);

    do_reset();
    load(0, 8'b0000_0010);
    load(1, 8'b0000_0100);
    load(2, 8'b0000_0111);
    run = 1;
    for (int i = 0; i < 3000 && gen1 != 16'd32; i++) tick();
    chk("glider_gen", 64'(gen1), 64'd32);
    chk("glider_grid", 64'(u1.q.cur), 64'h00000000_00070402);
    chk("glider_halted", 64'(halted1), 64'h0);
    run = 0;
    repeat (30) tick();

    do_reset();
    load(3, 8'b0001_1100);
    step = 1;
    tick();
    step = 0;
    repeat (4) tick();
    chk("abort_rc", 64'(u1.q.rc), 64'h4);
    reset = 0;
    tick();
    chk("abort_row", 64'(row1), 64'h0);
    chk("abort_col", 64'(col1), 64'hFF);
    chk("abort_busy", 64'(busy1), 64'h0);
    chk("abort_halted", 64'(halted1), 64'h0);
    chk("abort_gen", 64'(gen1), 64'h0);
    chk("abort_cur", 64'(u1.q.cur), 64'h0);
    reset = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
